t5_xalu: RTL



---
 rtl/t5_pkg.sv | 36 +++
 rtl/t5_xalu_mdu.sv | 173 +++++++++++++++++
 rtl/t5_xalu.sv | 122 ++++++++++++
 3 files changed

// File: rtl/t5_pkg.sv
// Shared constants for the T5 execute-stage ALU.
// Contents: opcode[6:2] values, funct3 encodings for base and M-extension
// ops, and the multiply/divide sequencer state type.
package t5_pkg;

    localparam logic [4:0] OPC_OP    = 5'h0C;
    localparam logic [4:0] OPC_OPIMM = 5'h04;

    // Base integer funct3
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    // M-extension funct3
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/t5_xalu_mdu.sv
// Iterative multiply/divide datapath for t5_xalu.
// Radix-2 shift-add multiply and restoring divide over a 2*XLEN accumulator,
// one bit per enabled cycle, with magnitude/sign handling around the core.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_ena          enable; low freezes every register
//   i_start        start an M-op (caller already qualified it with idle/enable)
//   i_fn3          M-ext funct3
//   i_op1, i_op2   operands
//   o_idle_c       sequencer is idle (decode of state register)
//   o_done_c       sequencer is in DONE; o_res_c is the final result
//   o_busy         registered busy flag
//   o_res_c        sign-corrected, half/quotient/remainder-selected result
module t5_xalu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ena,
    input  logic            i_start,
    input  logic [2:0]      i_fn3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_idle_c,
    output logic            o_done_c,
    output logic            o_busy,
    output logic [XLEN-1:0] o_res_c
);
    import t5_pkg::*;

    localparam int unsigned SLEN = $clog2(XLEN);
    localparam int unsigned AW   = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state, w_state_nxt;
    logic [SLEN-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0]   r_acc, w_acc_nxt;
    logic [XLEN-1:0] r_opb, w_opb_nxt;
    logic            r_neg_lo, w_neg_lo_nxt;
    logic            r_neg_hi, w_neg_hi_nxt;
    logic [2:0]      r_fn3, w_fn3_nxt;
    logic            r_busy, w_busy_nxt;

    // Issue-time operand conditioning
    logic            w_div_sgn, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div0, w_ovf;

    assign w_div_sgn = (i_fn3 == F3_DIV) || (i_fn3 == F3_REM);
    assign w_a_sgn   = i_fn3[2] ? w_div_sgn : ((i_fn3 == F3_MULH) || (i_fn3 == F3_MULHSU));
    assign w_b_sgn   = i_fn3[2] ? w_div_sgn : (i_fn3 == F3_MULH);
    assign w_a_neg   = w_a_sgn & i_op1[XLEN-1];
    assign w_b_neg   = w_b_sgn & i_op2[XLEN-1];
    assign w_a_mag   = w_a_neg ? -i_op1 : i_op1;
    assign w_b_mag   = w_b_neg ? -i_op2 : i_op2;
    assign w_div0    = i_fn3[2] & (i_op2 == '0);
    assign w_ovf     = i_fn3[2] & w_div_sgn & (i_op1 == MIN_NEG) & (&i_op2);

    // Multiply step: add multiplicand into the high half when the LSB is set, then shift right
    logic [XLEN:0]   w_mul_sum;
    logic [AW-1:0]   w_mul_acc;
    assign w_mul_sum = {1'b0, r_acc[AW-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide step: accumulator holds {remainder, dividend/quotient}
    logic [XLEN:0]   w_rsh, w_diff;
    logic [AW-1:0]   w_div_acc;
    assign w_rsh     = {r_acc[AW-1:XLEN], r_acc[XLEN-1]};
    assign w_diff    = w_rsh - {1'b0, r_opb};
    assign w_div_acc = w_diff[XLEN] ? {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Next-state and datapath update
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_opb_nxt    = r_opb;
        w_neg_lo_nxt = r_neg_lo;
        w_neg_hi_nxt = r_neg_hi;
        w_fn3_nxt    = r_fn3;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_fn3_nxt    = i_fn3;
                    w_cnt_nxt    = SLEN'(XLEN - 1);
                    w_neg_lo_nxt = w_a_neg ^ w_b_neg;
                    w_neg_hi_nxt = w_a_neg;
                    w_opb_nxt    = w_b_mag;
                    if (w_div0) begin
                        // quotient all ones, remainder = dividend, no sign fixup
                        w_acc_nxt    = {i_op1, {XLEN{1'b1}}};
                        w_neg_lo_nxt = 1'b0;
                        w_neg_hi_nxt = 1'b0;
                        w_state_nxt  = DONE;
                    end else if (w_ovf) begin
                        // quotient = dividend, remainder = 0
                        w_acc_nxt    = {{XLEN{1'b0}}, i_op1};
                        w_neg_lo_nxt = 1'b0;
                        w_neg_hi_nxt = 1'b0;
                        w_state_nxt  = DONE;
                    end else if (i_fn3[2]) begin
                        w_acc_nxt    = {{XLEN{1'b0}}, w_a_mag};
                        w_state_nxt  = DIV;
                    end else begin
                        w_acc_nxt    = {{XLEN{1'b0}}, w_b_mag};
                        w_opb_nxt    = w_a_mag;
                        w_state_nxt  = MUL;
                    end
                end
            end
            MUL: begin
                w_acc_nxt = w_mul_acc;
                if (r_cnt == '0) w_state_nxt = DONE;
                else             w_cnt_nxt   = r_cnt - SLEN'(1);
            end
            DIV: begin
                w_acc_nxt = w_div_acc;
                if (r_cnt == '0) w_state_nxt = DONE;
                else             w_cnt_nxt   = r_cnt - SLEN'(1);
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_fn3    <= '0;
            r_busy   <= 1'b0;
        end else if (i_ena) begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_opb    <= w_opb_nxt;
            r_neg_lo <= w_neg_lo_nxt;
            r_neg_hi <= w_neg_hi_nxt;
            r_fn3    <= w_fn3_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Sign fixup and result selection
    logic [AW-1:0]   w_prod;
    logic [XLEN-1:0] w_quo, w_rem;
    assign w_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_quo  = r_neg_lo ? -r_acc[XLEN-1:0]  : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_hi ? -r_acc[AW-1:XLEN] : r_acc[AW-1:XLEN];

    always_comb begin
        o_res_c = '0;
        case (r_fn3)
            F3_MUL:                       o_res_c = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: o_res_c = w_prod[AW-1:XLEN];
            F3_DIV, F3_DIVU:              o_res_c = w_quo;
            F3_REM, F3_REMU:              o_res_c = w_rem;
            default:                      o_res_c = '0;
        endcase
    end

    assign o_idle_c = (r_state == IDLE);
    assign o_done_c = (r_state == DONE);
    assign o_busy   = r_busy;

endmodule

// File: rtl/t5_xalu.sv
// T5 execute-stage ALU: single-cycle base integer ops plus RV M-extension
// through the iterative t5_xalu_mdu sequencer.
// Build option: define T5_XALU_FASTMUL_EN for single-cycle multiplies
// (divides stay iterative).
// Ports:
//   sclk, srst   clock, asynchronous active-high reset
//   sena         pipeline enable; low freezes all state
//   dvld         issue request (ignored unless idle)
//   dopc         opcode[6:2]; dfn3 funct3; dfn7 funct7
//   dop1, dop2   rs1 and rs2/immediate operands
//   xbsy         busy; upstream holds operands and may not issue
//   mvld         one-cycle result valid
//   malu         result
module t5_xalu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic            dvld,
    input  logic [4:0]      dopc,
    input  logic [2:0]      dfn3,
    input  logic [6:0]      dfn7,
    input  logic [XLEN-1:0] dop1,
    input  logic [XLEN-1:0] dop2,
    output logic            xbsy,
    output logic            mvld,
    output logic [XLEN-1:0] malu
);
    import t5_pkg::*;

    localparam int unsigned SLEN = $clog2(XLEN);

    logic            w_is_op, w_is_base, w_is_mop, w_sub, w_sra;
    logic            w_mdu_idle, w_mdu_done, w_mdu_start, w_issue, w_fast_mul;
    logic [XLEN-1:0] w_mdu_res, w_alu, w_sra_res, w_mul_res;
    logic [SLEN-1:0] w_shamt;
    logic            r_mvld;
    logic [XLEN-1:0] r_malu;
    logic            w_unused;

    // Decode; dfn7[0] is instruction bit 25, dfn7[5] is bit 30
    assign w_is_op   = (dopc == OPC_OP);
    assign w_is_base = (w_is_op & ~dfn7[0]) | (dopc == OPC_OPIMM);
    assign w_is_mop  = w_is_op & dfn7[0];
    assign w_sub     = w_is_op & dfn7[5];
    assign w_sra     = dfn7[5];
    assign w_shamt   = dop2[SLEN-1:0];
    assign w_issue   = dvld & sena & w_mdu_idle;
    assign w_unused  = ^{dfn7[6], dfn7[4:1]};

    // Base integer ALU
    assign w_sra_res = $signed(dop1) >>> w_shamt;
    always_comb begin
        w_alu = '0;
        case (dfn3)
            F3_ADD:  w_alu = w_sub ? (dop1 - dop2) : (dop1 + dop2);
            F3_SLL:  w_alu = dop1 << w_shamt;
            F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(dop1) < $signed(dop2))};
            F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, (dop1 < dop2)};
            F3_XOR:  w_alu = dop1 ^ dop2;
            F3_SR:   w_alu = w_sra ? w_sra_res : (dop1 >> w_shamt);
            F3_OR:   w_alu = dop1 | dop2;
            F3_AND:  w_alu = dop1 & dop2;
            default: w_alu = '0;
        endcase
    end

`ifdef T5_XALU_FASTMUL_EN
    // Single-cycle multiply: sign-extend per operand signedness, keep 2*XLEN product
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_mul_p;
    assign w_fast_mul = w_is_mop & ~dfn3[2];
    assign w_mul_a    = {{XLEN{((dfn3 == F3_MULH) || (dfn3 == F3_MULHSU)) & dop1[XLEN-1]}}, dop1};
    assign w_mul_b    = {{XLEN{(dfn3 == F3_MULH) & dop2[XLEN-1]}}, dop2};
    assign w_mul_p    = w_mul_a * w_mul_b;
    assign w_mul_res  = (dfn3 == F3_MUL) ? w_mul_p[XLEN-1:0] : w_mul_p[2*XLEN-1:XLEN];
`else
    assign w_fast_mul = 1'b0;
    assign w_mul_res  = '0;
`endif

    assign w_mdu_start = w_issue & w_is_mop & ~w_fast_mul;

    t5_xalu_mdu #(.XLEN(XLEN)) u_mdu (
        .i_clk    (sclk),
        .i_rst    (srst),
        .i_ena    (sena),
        .i_start  (w_mdu_start),
        .i_fn3    (dfn3),
        .i_op1    (dop1),
        .i_op2    (dop2),
        .o_idle_c (w_mdu_idle),
        .o_done_c (w_mdu_done),
        .o_busy   (xbsy),
        .o_res_c  (w_mdu_res)
    );

    // Output register; mvld drops on any enabled edge that produces no result
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            r_malu <= '0;
            r_mvld <= 1'b0;
        end else if (sena) begin
            if (w_issue & w_is_base) begin
                r_malu <= w_alu;
                r_mvld <= 1'b1;
            end else if (w_issue & w_fast_mul) begin
                r_malu <= w_mul_res;
                r_mvld <= 1'b1;
            end else if (w_mdu_done) begin
                r_malu <= w_mdu_res;
                r_mvld <= 1'b1;
            end else begin
                r_mvld <= 1'b0;
            end
        end
    end

    assign malu = r_malu;
    assign mvld = r_mvld;

endmodule
